// File: rtl/seq_addsub_pkg.sv
// seq_addsub_pkg: shared types and helpers for the chunked adder/subtractor.
//   state_e : FSM encoding (IDLE, RUN, DONE)
//   clog2   : index-counter width helper (never returns less than 1)
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width needed to count 0..n-1; a one-chunk build still gets a 1-bit counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_addsub_if.sv
// seq_addsub_if: request/result bundle for seq_addsub.
//   master : drives start, sub, a, b; observes busy, done, sum, cout, ovf
//   slave  : the arithmetic unit side
interface seq_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/seq_addsub_chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple adder.
//   a, b    : CHUNK-bit operands
//   cin     : carry in
//   s       : CHUNK-bit sum
//   cout    : carry out of the top bit
//   msb_cin : carry into the top bit (cout ^ msb_cin flags signed overflow)
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] total;

  assign total   = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s       = total[CHUNK-1:0];
  assign cout    = total[CHUNK];
  // The sum bit is a^b^carry_in, so the carry into the MSB falls out of it.
  assign msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ total[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock,
// least-significant chunk first.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of seq_addsub_if
//              start/sub/a/b in; busy/done/sum/cout/ovf out
// A request is taken in IDLE or DONE; operands are latched (B pre-inverted for
// subtract, carry-in = sub), then NCHUNK RUN cycles fill the result, then
// DONE holds for one cycle with done=1.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_addsub_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = clog2(NCHUNK);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             run;
  logic             last;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_cout;
  logic             chunk_msb_cin;

  // Operands shift down one chunk per RUN cycle, so the live chunk is
  // always the low CHUNK bits.
  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a       (op_a_q[CHUNK-1:0]),
    .b       (op_b_q[CHUNK-1:0]),
    .cin     (carry_q),
    .s       (chunk_s),
    .cout    (chunk_cout),
    .msb_cin (chunk_msb_cin)
  );

  assign accept = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
  assign run    = (state_q == RUN);
  assign last   = (idx_q == IDX_W'(NCHUNK - 1));

  // Result slices: cleared on accept, written when their index is live.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_sum
    assign sum_d[gi*CHUNK +: CHUNK] =
      accept                          ? {CHUNK{1'b0}} :
      (run && idx_q == IDX_W'(gi))    ? chunk_s       :
                                        sum_q[gi*CHUNK +: CHUNK];
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      op_a_d  = bus.a;
      op_b_d  = bus.b ^ {WIDTH{bus.sub}};
      carry_d = bus.sub;
      idx_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (run) begin
      op_a_d  = op_a_q >> CHUNK;
      op_b_d  = op_b_q >> CHUNK;
      carry_d = chunk_cout;
      idx_d   = idx_q + IDX_W'(1);
      if (last) begin
        cout_d = chunk_cout;
        // Signed overflow: carry into the MSB differs from carry out of it.
        ovf_d  = chunk_cout ^ chunk_msb_cin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
